// File: rtl/data_bus_mem.sv
// data_bus_mem: data-side RAM and MMIO slave for the lab CPU core.
//   RAM of RAM_DEPTH 32-bit words at 0x0000_0000 with byte-lane writes,
//   cleared by a hardware sequencer after reset. MMIO window at 0x4000_0000:
//   0x00 TH, 0x04 TL, 0x08 TCON, 0x0C LED, 0x10 DIGI, 0x14 SYSTICK (RO).
//   Optional interval timer built only when macro TIMER_EN is defined;
//   otherwise TH/TL/TCON are unmapped and irq is tied low.
// Ports:
//   clk, reset (async, active-high)
//   req, we, be[3:0], addr[31:0], wdata[31:0]  - request from MEM stage
//   rdata[31:0], rvalid                         - registered read response
//   err                                         - rejected/unmapped pulse
//   busy                                        - clear sequencer active
//   led[LED_W-1:0], digi[DIGI_W-1:0], irq       - board I/O
module data_bus_mem #(
  parameter int unsigned RAM_DEPTH = 512,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned DIGI_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              err,
  output logic              busy,
  output logic [LED_W-1:0]  led,
  output logic [DIGI_W-1:0] digi,
  output logic              irq
);

  localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [31:0] MMIO_BASE = 32'h4000_0000;
  localparam logic [2:0]  OFF_TH    = 3'd0;
  localparam logic [2:0]  OFF_TL    = 3'd1;
  localparam logic [2:0]  OFF_TCON  = 3'd2;
  localparam logic [2:0]  OFF_LED   = 3'd3;
  localparam logic [2:0]  OFF_DIGI  = 3'd4;
  localparam logic [2:0]  OFF_TICK  = 3'd5;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] ptr_q, ptr_d;
  logic              clr_we_c;

  logic [31:0]       ram [RAM_DEPTH];
  logic [31:0]       systick_q;

  logic              idle_c, acc_c, rd_c, wr_c;
  logic              ram_hit_c, mmio_win_c, mmio_rd_ok_c, mmio_wr_ok_c;
  logic              ram_we_c, err_d_c;
  logic [2:0]        off_c;
  logic [RAM_AW-1:0] idx_c;
  logic [31:0]       mmio_rdata_c;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  // Clear sequencer: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy    <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy    <= (state_d == CLEAR);
    end
  end

  // Clear sequencer: one zero word per cycle, leave after the last word
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_we_c = 1'b0;
    if (state_q == CLEAR) begin
      clr_we_c = 1'b1;
      ptr_d    = ptr_q + RAM_AW'(1);
      if (ptr_q == RAM_AW'(RAM_DEPTH - 1)) begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    end
  end

  // Address decode
  assign idle_c     = (state_q == IDLE);
  assign acc_c      = req && idle_c;
  assign rd_c       = acc_c && !we;
  assign wr_c       = acc_c && we;
  assign ram_hit_c  = (addr[31:RAM_AW+2] == '0);
  assign mmio_win_c = (addr[31:5] == MMIO_BASE[31:5]);
  assign off_c      = addr[4:2];
  assign idx_c      = addr[RAM_AW+1:2];
  assign ram_we_c   = wr_c && ram_hit_c;

  // Which MMIO offsets exist for reads and for writes
  always_comb begin
    mmio_rd_ok_c = 1'b0;
    mmio_wr_ok_c = 1'b0;
    if (mmio_win_c) begin
      case (off_c)
        OFF_LED, OFF_DIGI: begin
          mmio_rd_ok_c = 1'b1;
          mmio_wr_ok_c = 1'b1;
        end
        OFF_TICK: mmio_rd_ok_c = 1'b1;
`ifdef TIMER_EN
        OFF_TH, OFF_TL, OFF_TCON: begin
          mmio_rd_ok_c = 1'b1;
          mmio_wr_ok_c = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Busy rejection, unmapped access or write to read-only register
  always_comb begin
    err_d_c = 1'b0;
    if (req) begin
      if (!idle_c)
        err_d_c = 1'b1;
      else if (we)
        err_d_c = !(ram_hit_c || mmio_wr_ok_c);
      else
        err_d_c = !(ram_hit_c || mmio_rd_ok_c);
    end
  end

  // Single-port RAM; the clear sequencer owns the port while busy
  always_ff @(posedge clk) begin
    if (clr_we_c) begin
      ram[ptr_q] <= '0;
    end else if (ram_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[idx_c][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

`ifdef TIMER_EN
  logic [31:0] th_q, tl_q;
  logic [2:0]  tcon_q;
  logic        ovf_c, irq_set_c;
  logic        wr_th_c, wr_tl_c, wr_tcon_c;

  assign ovf_c     = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
  assign irq_set_c = ovf_c && tcon_q[1];
  assign wr_th_c   = wr_c && mmio_win_c && (off_c == OFF_TH);
  assign wr_tl_c   = wr_c && mmio_win_c && (off_c == OFF_TL);
  assign wr_tcon_c = wr_c && mmio_win_c && (off_c == OFF_TCON);

  // Interval timer: software TL write beats count/reload, overflow-set of
  // the interrupt bit beats a software TCON write so no interrupt is lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      if (wr_th_c) th_q <= wdata;
      if (wr_tl_c)        tl_q <= wdata;
      else if (ovf_c)     tl_q <= th_q;
      else if (tcon_q[0]) tl_q <= tl_q + 32'd1;
      if (wr_tcon_c)      tcon_q <= wdata[2:0] | {irq_set_c, 2'b00};
      else if (irq_set_c) tcon_q[2] <= 1'b1;
    end
  end

  assign irq = tcon_q[2];
`else
  assign irq = 1'b0;
`endif

  // MMIO read mux, registers zero-extended to 32 bits
  always_comb begin
    mmio_rdata_c = '0;
    case (off_c)
      OFF_LED:  mmio_rdata_c = 32'(led);
      OFF_DIGI: mmio_rdata_c = 32'(digi);
      OFF_TICK: mmio_rdata_c = systick_q;
`ifdef TIMER_EN
      OFF_TH:   mmio_rdata_c = th_q;
      OFF_TL:   mmio_rdata_c = tl_q;
      OFF_TCON: mmio_rdata_c = 32'(tcon_q);
`endif
      default: ;
    endcase
  end

  // LED, DIGI and free-running system tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led       <= '0;
      digi      <= '0;
      systick_q <= '0;
    end else begin
      systick_q <= systick_q + 32'd1;
      if (wr_c && mmio_win_c && (off_c == OFF_LED))  led  <= wdata[LED_W-1:0];
      if (wr_c && mmio_win_c && (off_c == OFF_DIGI)) digi <= wdata[DIGI_W-1:0];
    end
  end

  // Registered response; unmapped reads return zero with rvalid and err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= rd_c;
      err    <= err_d_c;
      if (rd_c) begin
        if (ram_hit_c)         rdata <= ram[idx_c];
        else if (mmio_rd_ok_c) rdata <= mmio_rdata_c;
        else                   rdata <= '0;
      end
    end
  end

endmodule
